// File: rtl/seq_pkg.sv
// Shared types and tempo constants for the step sequencer transport/pattern logic.
package seq_pkg;

  localparam int BPM_W           = 10;
  localparam int SEQ_DEFAULT_BPM = 120;
  localparam int SEQ_MIN_BPM     = 30;
  localparam int SEQ_MAX_BPM     = 511;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

  // Index width that stays legal for single-entry dimensions.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_transport_ctrl_if.sv
// Pattern-cell write bus between the sequencer host (master) and the transport controller (slave).
interface seq_transport_ctrl_if
  import seq_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int NUM_STEPS  = 16
);

  localparam int TW = idx_width(NUM_TRACKS);
  localparam int SW = idx_width(NUM_STEPS);

  logic          WrEn;
  logic [TW-1:0] WrTrack;
  logic [SW-1:0] WrStep;
  logic          WrData;

  modport master (output WrEn, WrTrack, WrStep, WrData);
  modport slave  (input  WrEn, WrTrack, WrStep, WrData);

endinterface

// File: rtl/seq_pattern_ram.sv
// Track x step hit pattern: single-bit write port, combinational full-column read.
module seq_pattern_ram
  import seq_pkg::*;
#(
  parameter  int NUM_TRACKS = 4,
  parameter  int NUM_STEPS  = 16,
  localparam int SW         = idx_width(NUM_STEPS)
) (
  input  logic                  Clock,
  input  logic                  nReset,
  seq_transport_ctrl_if.slave   wr_bus,
  input  logic [SW-1:0]         rd_step_i,
  output logic [NUM_TRACKS-1:0] rd_col_o
);

  logic [NUM_TRACKS-1:0][NUM_STEPS-1:0] cells_q;

  // NOTE: the pattern must come up empty, so this array is reset like any other
  // register; it is a handful of flops, not a RAM macro that lacks a reset.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      cells_q <= '0;
    end else if (wr_bus.WrEn) begin
      cells_q[wr_bus.WrTrack][wr_bus.WrStep] <= wr_bus.WrData;
    end
  end

  // Read sees the pre-write contents, so a same-cycle write plays the old value.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    rd_col_o = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      rd_col_o[t] = cells_q[t][rd_step_i];
    end
  end

endmodule

// File: rtl/seq_transport_ctrl.sv
// Transport/pattern controller: tempo, start/stop FSM, step pointer, per-track triggers.
// Optional: define SEQ_LOOP_LEN_EN to add the LoopLen input (programmable last step).
module seq_transport_ctrl
  import seq_pkg::*;
#(
  parameter  int NUM_TRACKS  = 4,
  parameter  int NUM_STEPS   = 16,
  parameter  int DEFAULT_BPM = SEQ_DEFAULT_BPM,
  parameter  int MIN_BPM     = SEQ_MIN_BPM,
  parameter  int MAX_BPM     = SEQ_MAX_BPM,
  localparam int SW          = idx_width(NUM_STEPS)
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  Play,
  input  logic                  Stop,
  input  logic                  BpmUp,
  input  logic                  BpmDown,
  seq_transport_ctrl_if.slave   wr_bus,
`ifdef SEQ_LOOP_LEN_EN
  input  logic [SW-1:0]         LoopLen,
`endif
  input  logic                  Step,
  output logic [BPM_W-1:0]      BPM,
  output logic                  nStart,
  output logic [NUM_TRACKS-1:0] Trigger,
  output logic [SW-1:0]         CurStep,
  output logic                  Playing
);

  localparam logic [BPM_W-1:0] BPM_RST = BPM_W'(DEFAULT_BPM);
  localparam logic [BPM_W-1:0] BPM_LO  = BPM_W'(MIN_BPM);
  localparam logic [BPM_W-1:0] BPM_HI  = BPM_W'(MAX_BPM);

  seq_state_e            state_q;
  logic [SW-1:0]         ptr_q;
  logic [SW-1:0]         cur_step_q;
  logic [BPM_W-1:0]      bpm_q;
  logic [BPM_W-1:0]      bpm_d;
  logic                  nstart_q;
  logic                  playing_q;
  logic [NUM_TRACKS-1:0] trigger_q;
  logic [NUM_TRACKS-1:0] col;
  logic                  tempo_chg;
  logic [SW-1:0]         play_idx;
  logic [SW-1:0]         next_idx;

  always_comb begin
    bpm_d     = bpm_q;
    tempo_chg = 1'b0;
    if (BpmUp && !BpmDown && (bpm_q < BPM_HI)) begin
      bpm_d     = bpm_q + BPM_W'(1);
      tempo_chg = 1'b1;
    end else if (BpmDown && !BpmUp && (bpm_q > BPM_LO)) begin
      bpm_d     = bpm_q - BPM_W'(1);
      tempo_chg = 1'b1;
    end
  end

`ifdef SEQ_LOOP_LEN_EN
  // A pointer stranded beyond a freshly shortened loop restarts at step 0.
  always_comb begin
    play_idx = (ptr_q > LoopLen) ? '0 : ptr_q;
    next_idx = (play_idx >= LoopLen) ? '0 : play_idx + SW'(1);
  end
`else
  // NUM_STEPS is a power of two, so the increment wraps on its own.
  always_comb begin
    play_idx = ptr_q;
    next_idx = ptr_q + SW'(1);
  end
`endif

  seq_pattern_ram #(
    .NUM_TRACKS (NUM_TRACKS),
    .NUM_STEPS  (NUM_STEPS)
  ) u_pattern (
    .Clock     (Clock),
    .nReset    (nReset),
    .wr_bus    (wr_bus),
    .rd_step_i (play_idx),
    .rd_col_o  (col)
  );

  // NOTE: all state here is updated with <= so every register sees pre-edge values.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cur_step_q <= '0;
      bpm_q      <= BPM_RST;
      nstart_q   <= 1'b1;
      playing_q  <= 1'b0;
      trigger_q  <= '0;
    end else begin
      bpm_q     <= bpm_d;
      trigger_q <= '0;
      if (Stop) begin
        state_q    <= IDLE;
        ptr_q      <= '0;
        cur_step_q <= '0;
        nstart_q   <= 1'b1;
        playing_q  <= 1'b0;
      end else if (Play) begin
        state_q   <= ARM;
        ptr_q     <= '0;
        nstart_q  <= 1'b0;
        playing_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: ;
          ARM: begin
            state_q  <= RUN;
            nstart_q <= 1'b1;
          end
          RUN: begin
            if (Step) begin
              trigger_q  <= col;
              cur_step_q <= play_idx;
              ptr_q      <= next_idx;
            end
            // Re-arm so the BPM counter reloads the new period; pointer is kept.
            if (tempo_chg) begin
              state_q  <= ARM;
              nstart_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            nstart_q  <= 1'b1;
            playing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign BPM     = bpm_q;
  assign nStart  = nstart_q;
  assign Trigger = trigger_q;
  assign CurStep = cur_step_q;
  assign Playing = playing_q;

endmodule
